// File: rtl/serial_comparator.sv
// Multi-cycle magnitude comparator: W bits per clock from the MSB chunk down, with unsigned or signed mode.
// Optional macro SERIAL_COMPARATOR_EARLY_EXIT_EN makes RUN end on the first deciding chunk.
module serial_comparator #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_signed,
  input  logic [N-1:0] i_left,
  input  logic [N-1:0] i_right,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_result_valid,
  output logic         o_greater,
  output logic         o_equal,
  output logic         o_less,
  output logic         o_greater_equal,
  output logic         o_not_equal,
  output logic         o_less_equal
);
  localparam int CHUNKS = N / W;
  localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_left;
  logic [N-1:0]  r_right;
  logic          r_signed;
  logic [IW-1:0] r_index;
  logic          r_decided;
  logic          r_gt;
  logic          r_lt;

  logic [N-1:0]  w_left_adj;
  logic [N-1:0]  w_right_adj;
  logic [W-1:0]  w_lchunk;
  logic [W-1:0]  w_rchunk;
  logic          w_chunk_gt;
  logic          w_chunk_lt;
  logic          w_gt_final;
  logic          w_lt_final;
  logic          w_last;

  // Flipping the sign bit maps two's complement onto offset binary, so an unsigned compare suffices.
  always_comb begin
    w_left_adj          = r_left;
    w_right_adj         = r_right;
    w_left_adj[N-1]     = r_left[N-1] ^ r_signed;
    w_right_adj[N-1]    = r_right[N-1] ^ r_signed;
  end

  assign w_lchunk   = w_left_adj[int'(r_index) * W +: W];
  assign w_rchunk   = w_right_adj[int'(r_index) * W +: W];
  assign w_chunk_gt = (w_lchunk > w_rchunk);
  assign w_chunk_lt = (w_lchunk < w_rchunk);
  assign w_gt_final = r_decided ? r_gt : w_chunk_gt;
  assign w_lt_final = r_decided ? r_lt : w_chunk_lt;

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  assign w_last = (r_index == '0) || (!r_decided && (w_chunk_gt || w_chunk_lt));
`else
  assign w_last = (r_index == '0);
`endif

  assign o_busy = (r_state == S_RUN);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_left          <= '0;
      r_right         <= '0;
      r_signed        <= 1'b0;
      r_index         <= '0;
      r_decided       <= 1'b0;
      r_gt            <= 1'b0;
      r_lt            <= 1'b0;
      o_done          <= 1'b0;
      o_result_valid  <= 1'b0;
      o_greater       <= 1'b0;
      o_equal         <= 1'b0;
      o_less          <= 1'b0;
      o_greater_equal <= 1'b0;
      o_not_equal     <= 1'b0;
      o_less_equal    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_left         <= i_left;
            r_right        <= i_right;
            r_signed       <= i_signed;
            r_index        <= IW'(CHUNKS - 1);
            r_decided      <= 1'b0;
            r_gt           <= 1'b0;
            r_lt           <= 1'b0;
            o_result_valid <= 1'b0;
            r_state        <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (!r_decided && (w_chunk_gt || w_chunk_lt)) begin
            r_decided <= 1'b1;
            r_gt      <= w_chunk_gt;
            r_lt      <= w_chunk_lt;
          end
          if (w_last) begin
            r_state         <= S_DONE;
            o_done          <= 1'b1;
            o_result_valid  <= 1'b1;
            o_greater       <= w_gt_final;
            o_less          <= w_lt_final;
            o_equal         <= !(w_gt_final || w_lt_final);
            o_greater_equal <= !w_lt_final;
            o_not_equal     <= w_gt_final || w_lt_final;
            o_less_equal    <= !w_gt_final;
          end else begin
            r_index <= r_index - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator (N=16, W=4); expected latency follows SERIAL_COMPARATOR_EARLY_EXIT_EN.
module tb_serial_comparator;
  localparam int N = 16;
  localparam int W = 4;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  // flag vector order: {gt, eq, lt, ge, ne, le}
  localparam logic [5:0] F_GT = 6'b100110;
  localparam logic [5:0] F_EQ = 6'b010101;
  localparam logic [5:0] F_LT = 6'b001011;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [N-1:0] left = '0;
  logic [N-1:0] right = '0;
  logic busy, done, valid, gt, eq, lt, ge, ne, le;
  logic [5:0] flags;
  int checks = 0;
  int failures = 0;

  assign flags = {gt, eq, lt, ge, ne, le};

  always #5 clk = ~clk;

  serial_comparator #(.N(N), .W(W)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_signed(sgn),
    .i_left(left), .i_right(right),
    .o_busy(busy), .o_done(done), .o_result_valid(valid),
    .o_greater(gt), .o_equal(eq), .o_less(lt),
    .o_greater_equal(ge), .o_not_equal(ne), .o_less_equal(le)
  );

  // Drive a start pulse; returns #1 after the start edge.
  task automatic issue(input logic [N-1:0] l, input logic [N-1:0] r, input logic s);
    @(negedge clk);
    left = l; right = r; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after the start edge until o_done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, valid, flags} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", {busy, done, valid, flags}, 9'b0);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_equal;
    int lat;
    issue(16'h1234, 16'h1234, 1'b0);
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL eq_busy busy=%b valid=%b want busy=1 valid=0", busy, valid);
    end
    wait_done(lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL eq_latency got=%0d want=4", lat); end
    checks++;
    if (flags !== F_EQ || valid !== 1'b1) begin
      failures++;
      $display("FAIL eq_flags got=%b valid=%b want=%b valid=1", flags, valid, F_EQ);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b1 || flags !== F_EQ) begin
      failures++;
      $display("FAIL eq_hold done=%b busy=%b valid=%b flags=%b want 0 0 1 %b", done, busy, valid, flags, F_EQ);
    end
  endtask

  task automatic test_signed_mode;
    int lat;
    issue(16'h8000, 16'h0001, 1'b0);
    wait_done(lat);
    checks++;
    if (flags !== F_GT) begin failures++; $display("FAIL unsigned_8000 got=%b want=%b", flags, F_GT); end
    issue(16'h8000, 16'h0001, 1'b1);
    wait_done(lat);
    checks++;
    if (flags !== F_LT) begin failures++; $display("FAIL signed_8000 got=%b want=%b", flags, F_LT); end
    checks++;
    if (lat != (EE ? 1 : 4)) begin failures++; $display("FAIL signed_8000_lat got=%0d want=%0d", lat, EE ? 1 : 4); end
  endtask

  task automatic test_early_exit;
    int lat;
    issue(16'hF000, 16'h0000, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != (EE ? 1 : 4) || flags !== F_GT) begin
      failures++;
      $display("FAIL ee_f000 lat=%0d flags=%b want lat=%0d flags=%b", lat, flags, EE ? 1 : 4, F_GT);
    end
    issue(16'h1230, 16'h1231, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 4 || flags !== F_LT) begin
      failures++;
      $display("FAIL ee_1230 lat=%0d flags=%b want lat=4 flags=%b", lat, flags, F_LT);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(16'h0001, 16'h0002, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; left = 16'h0009; right = 16'h0002;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 4 || flags !== F_LT) begin
      failures++;
      $display("FAIL ignore_start lat=%0d flags=%b want lat=4 flags=%b", lat, flags, F_LT);
    end
    // Still in the DONE cycle: a new start must be accepted.
    start = 1'b1; left = 16'h0005; right = 16'h0003;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept busy=%b valid=%b want busy=1 valid=0", busy, valid);
    end
    wait_done(lat);
    checks++;
    if (lat != (EE ? 4 : 4) || flags !== F_GT) begin
      failures++;
      $display("FAIL b2b_result lat=%0d flags=%b want lat=4 flags=%b", lat, flags, F_GT);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    logic seen_done;
    issue(16'h0003, 16'h0004, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, valid, flags} !== 9'b0) begin
      failures++;
      $display("FAIL abort_outputs got=%b want=%b", {busy, done, valid, flags}, 9'b0);
    end
    @(negedge clk); rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b want=0", seen_done); end
    issue(16'hFFFF, 16'hFFFE, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != 4 || flags !== F_GT) begin
      failures++;
      $display("FAIL after_abort lat=%0d flags=%b want lat=4 flags=%b", lat, flags, F_GT);
    end
  endtask

  task automatic test_signed_boundaries;
    int lat;
    issue(16'h7FFF, 16'h8000, 1'b1);
    wait_done(lat);
    checks++;
    if (flags !== F_GT) begin failures++; $display("FAIL s_7fff_8000 got=%b want=%b", flags, F_GT); end
    issue(16'hFFFF, 16'h0000, 1'b1);
    wait_done(lat);
    checks++;
    if (flags !== F_LT) begin failures++; $display("FAIL s_ffff_0000 got=%b want=%b", flags, F_LT); end
    issue(16'hFFFF, 16'h0000, 1'b0);
    wait_done(lat);
    checks++;
    if (flags !== F_GT) begin failures++; $display("FAIL u_ffff_0000 got=%b want=%b", flags, F_GT); end
    issue(16'h8000, 16'h8000, 1'b1);
    wait_done(lat);
    checks++;
    if (flags !== F_EQ || lat != 4) begin
      failures++;
      $display("FAIL s_8000_eq lat=%0d flags=%b want lat=4 flags=%b", lat, flags, F_EQ);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_signed_mode();
    test_early_exit();
    test_back_to_back();
    test_reset_abort();
    test_signed_boundaries();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
- Multi-cycle magnitude comparator for wide operands. Compares W bits per clock, starting at the most significant chunk.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Uses a start/busy/done handshake and registers all six relational flags.
- Intended for wide datapaths where a single-cycle N-bit compare would limit timing; produces the same flag set as the combinational comparator.

Parameters:
- N, 16, operand width in bits; must be a multiple of W.
- W, 4, chunk width compared per cycle; 1 <= W <= N.
- CHUNKS, N/W, derived localparam; not overridable.

Ports:
- i_clock  input  1  system clock; all state updates on the rising edge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_start  input  1  request a compare; sampled on the rising edge.
- i_signed  input  1  1 = two's-complement compare, 0 = unsigned; latched with i_start.
- i_left  input  N  left operand; latched with i_start.
- i_right  input  N  right operand; latched with i_start.
- o_busy  output  1  high while a compare is in progress (RUN state).
- o_done  output  1  one-cycle pulse when the result flags are updated.
- o_result_valid  output  1  high from the first o_done until the next accepted start or reset.
- o_greater, o_equal, o_less, o_greater_equal, o_not_equal, o_less_equal  output  1 each  registered relational flags, left op right.

Behaviour:
- Reset: state IDLE; all outputs 0; internal operand, index and decision registers cleared. Reset asserted mid-operation aborts immediately; no o_done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with i_start=1:
  - Latch i_left, i_right and i_signed; index <= CHUNKS-1; clear the decided flag.
  - o_result_valid <= 0; next state RUN.
  - A start in DONE is accepted; back-to-back operations are legal.
- DONE without start: next state IDLE.
- i_start while in RUN is ignored. Latched operands and mode are unaffected.
- RUN, one chunk per edge, chunk = bits [index*W+W-1 : index*W]:
  - Signed mode: invert bit N-1 of both operands before comparing the top chunk (offset-binary trick); lower chunks are compared unsigned.
  - If not yet decided and the chunks differ: record gt/lt and set decided.
  - If the chunks are equal: no change.
  - After a chunk has decided the result, later chunks are ignored.
  - When index == 0: next state DONE. Otherwise index decrements.
- Transition into DONE (same edge):
  - o_done <= 1 for exactly one cycle.
  - Flags are written: if never decided, equal=1; gt/lt otherwise. The derived flags are ge = gt|eq, ne = ~eq, le = lt|eq.
  - o_result_valid <= 1.
- Flags hold their last value until the next transition into DONE or reset.
- Latency without early exit: o_done is high during the cycle following the CHUNKS-th edge after the start edge, i.e. CHUNKS cycles after start. This is independent of the data.
- o_busy = 1 exactly in RUN.
- W == N gives CHUNKS=1: one RUN cycle, so o_done follows 1 cycle after start.
- Exactly one of o_greater, o_equal, o_less is high whenever o_result_valid=1.

Optional Feature:
- Macro: SERIAL_COMPARATOR_EARLY_EXIT_EN.
- Defined: the FSM leaves RUN for DONE on the same edge that a chunk decides the result. Latency is k cycles, where k is the 1-based position (from the MSB end) of the first differing chunk; equal operands still take CHUNKS cycles.
- Undefined: fixed CHUNKS-cycle latency as described above.
- Flag values are identical in both builds.

Test Plan:
- N=16, W=4, unsigned, 0x1234 vs 0x1234 -> o_done 4 cycles after start; eq=1, ge=1, le=1, gt=ne=lt=0.
- 0x8000 vs 0x0001, i_signed=0 -> gt=1, ge=1, ne=1. Same operands with i_signed=1 -> lt=1, le=1, ne=1.
- Early exit build, 0xF000 vs 0x0000 -> o_done 1 cycle after start, gt=1. 0x1230 vs 0x1231 -> o_done after 4 cycles, lt=1. Non-early build: both take 4 cycles.
- Start 0x0001 vs 0x0002, pulse i_start again with 0x0009 vs 0x0002 on the 2nd RUN cycle -> ignored; result lt=1. A new start in the DONE cycle is accepted and o_busy rises on the next edge.
- Assert i_reset on the 2nd RUN cycle -> all outputs 0 immediately, no o_done; a subsequent start of 0xFFFF vs 0xFFFE unsigned gives gt=1 after 4 cycles.
- Signed boundaries: 0x7FFF vs 0x8000 -> gt=1; 0xFFFF vs 0x0000 -> lt=1 (signed) and gt=1 (unsigned).
